// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port SRAM.
// Each granted access takes three cycles: IDLE (sample and latch),
// ACCESS (one SRAM cycle), and DONE (one-cycle ack pulse to the winner).
// Configuration macro SRAM_ARB_FIXED_PRI_EN:
//   - Defined: requester 0 always wins when both requesters ask at once.
//   - Undefined (default): ties are resolved round-robin against the last grant.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_in,
  output logic              sram_write_en,
  input  logic [DATA_W-1:0] sram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic              grant_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              winner;

`ifndef SRAM_ARB_FIXED_PRI_EN
  // Id of the most recently granted requester. It resets to 1 so that
  // requester 0 wins the first tie.
  logic              last_grant;
`endif

  // The SRAM sees only the latched request. Later changes on the requester
  // ports therefore cannot disturb an access that is already in progress.
  assign sram_address = lat_addr;
  assign sram_data_in = lat_wdata;

`ifdef SRAM_ARB_FIXED_PRI_EN
  // Fixed priority: requester 0 wins whenever it is asking.
  always_comb begin
    winner = 1'b0;
    if (!req0) winner = 1'b1;
  end
`else
  // Round-robin: on a tie, the requester that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_grant;
    else if (!req0)   winner = 1'b1;
  end
`endif

  // Single state machine. It latches the winner's request, runs exactly one
  // SRAM cycle, then pulses the winner's ack. All outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant_id      <= 1'b0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      busy          <= 1'b0;
      sram_write_en <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRI_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            grant_id      <= winner;
            lat_we        <= winner ? we1 : we0;
            lat_addr      <= winner ? addr1 : addr0;
            lat_wdata     <= winner ? wdata1 : wdata0;
            sram_write_en <= winner ? we1 : we0;
            busy          <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRI_EN
            last_grant    <= winner;
`endif
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          sram_write_en <= 1'b0;
          if (!lat_we) begin
            if (grant_id) rdata1 <= sram_data_out;
            else          rdata0 <= sram_data_out;
          end
          if (grant_id) ack1 <= 1'b1;
          else          ack0 <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0          <= 1'b0;
          ack1          <= 1'b0;
          busy          <= 1'b0;
          sram_write_en <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven and scoreboard-based bench for sram_arbiter,
// with a behavioural SRAM attached. Define SRAM_ARB_FIXED_PRI_EN here too
// when building the design with fixed priority.
module tb_sram_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, sram_write_en;
  logic [7:0] rdata0, rdata1, sram_data_in, sram_data_out;
  logic [3:0] sram_address;

  logic [7:0] mem [16];

  typedef struct {
    bit         who;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit         who;
    bit         we;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         compared;
  int         mismatched;
  int         cycle;
  int         wr_count;
  logic [3:0] wr_addr;
  logic [7:0] mdl0, mdl1;

  sram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .sram_address(sram_address), .sram_data_in(sram_data_in),
    .sram_write_en(sram_write_en), .sram_data_out(sram_data_out)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_address] <= sram_data_in;
  end
  assign sram_data_out = mem[sram_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sram_write_en) begin
      wr_count++;
      wr_addr = sram_address;
    end
    if (ack0 && ack1) begin
      check("dual_ack", 32'(2'b11), 32'(2'b01));
    end else if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({ack1, ack0}), 32'(0));
      end else begin
        e = sb.pop_front();
        check("ack_who", 32'(ack1), 32'(e.who));
        if (!e.we) begin
          if (e.who) mdl1 = e.rdata;
          else       mdl0 = e.rdata;
        end
        check("rdata0", 32'(rdata0), 32'(mdl0));
        check("rdata1", 32'(rdata1), 32'(mdl1));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle++;
    checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v);
    int wr_before;
    int lat;
    bit got;
    wr_before = wr_count;
    if (v.who) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    sb.push_back('{who: v.who, we: v.we, rdata: v.exp_rdata});
    got = 1'b0;
    tick();
    lat = 1;
    check("busy_access", 32'(busy), 32'(1));
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (v.who ? ack1 : ack0) got = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("ack_seen", 32'(got), 32'(1));
    if (got) check("ack_latency", 32'(lat), 32'(2));
    else     sb.delete();
    check("write_cycles", 32'(wr_count - wr_before), 32'(v.we));
    tick();
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    vec_t tbl[7];
    vec_t v;
    int   nacks;
    int   last;
    int   n;
    int   wr_before;
    bit   got;

    tbl[0] = '{who: 1'b0, we: 1'b1, addr: 4'd3, wdata: 8'hA5, exp_rdata: 8'h00};
    tbl[1] = '{who: 1'b1, we: 1'b0, addr: 4'd3, wdata: 8'h00, exp_rdata: 8'hA5};
    tbl[2] = '{who: 1'b1, we: 1'b1, addr: 4'd7, wdata: 8'h3C, exp_rdata: 8'h00};
    tbl[3] = '{who: 1'b0, we: 1'b0, addr: 4'd7, wdata: 8'h00, exp_rdata: 8'h3C};
    tbl[4] = '{who: 1'b0, we: 1'b0, addr: 4'd3, wdata: 8'h00, exp_rdata: 8'hA5};
    tbl[5] = '{who: 1'b1, we: 1'b1, addr: 4'd3, wdata: 8'h5A, exp_rdata: 8'h00};
    tbl[6] = '{who: 1'b0, we: 1'b0, addr: 4'd3, wdata: 8'h00, exp_rdata: 8'h5A};

    compared = 0; mismatched = 0; cycle = 0; wr_count = 0; wr_addr = '0;
    mdl0 = 8'h00; mdl1 = 8'h00;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    tick();
    tick();
    check("rst_ack0", 32'(ack0), 32'(0));
    check("rst_ack1", 32'(ack1), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rdata0", 32'(rdata0), 32'(0));
    check("rst_rdata1", 32'(rdata1), 32'(0));
    check("rst_wen", 32'(sram_write_en), 32'(0));
    check("rst_addr", 32'(sram_address), 32'(0));
    check("rst_wdata", 32'(sram_data_in), 32'(0));
    reset = 1'b0;

    // Table vectors: single-requester writes and reads.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i]);
      if (i == 0) check("first_write_addr", 32'(wr_addr), 32'(3));
    end

    // Fill every address via requester 1, then read back via requester 0.
    for (int a = 0; a < 16; a++) begin
      v = '{who: 1'b1, we: 1'b1, addr: 4'(a), wdata: 8'(8'h10 + a), exp_rdata: 8'h00};
      applyStimulus(v);
      check("fill_addr", 32'(wr_addr), 32'(a));
    end
    for (int a = 0; a < 16; a++) begin
      v = '{who: 1'b0, we: 1'b0, addr: 4'(a), wdata: 8'h00, exp_rdata: 8'(8'h10 + a)};
      applyStimulus(v);
    end

    // Address and data change after the sample edge must be ignored.
    wr_before = wr_count;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 8'h5C;
    sb.push_back('{who: 1'b0, we: 1'b1, rdata: 8'h00});
    tick();
    check("late_change_addr", 32'(sram_address), 32'(2));
    addr0 = 4'd9; wdata0 = 8'hFF;
    got = 1'b0;
    n = 1;
    while (!got && n < 10) begin
      tick();
      n++;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    check("late_change_ack", 32'(got), 32'(1));
    if (!got) sb.delete();
    check("late_change_wcnt", 32'(wr_count - wr_before), 32'(1));
    check("late_change_waddr", 32'(wr_addr), 32'(2));
    tick();
    applyStimulus('{who: 1'b1, we: 1'b0, addr: 4'd2, wdata: 8'h00, exp_rdata: 8'h5C});
    applyStimulus('{who: 1'b1, we: 1'b0, addr: 4'd9, wdata: 8'h00, exp_rdata: 8'h19});

    // Both requesters held high after a reset.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mdl0 = 8'h00; mdl1 = 8'h00;
`ifdef SRAM_ARB_FIXED_PRI_EN
    for (int k = 0; k < 4; k++) sb.push_back('{who: 1'b0, we: 1'b0, rdata: 8'h13});
`else
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{who: 1'b0, we: 1'b0, rdata: 8'h13});
      else            sb.push_back('{who: 1'b1, we: 1'b0, rdata: 8'h15});
    end
`endif
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
    nacks = 0; last = 0; n = 0;
    while (nacks < 4 && n < 20) begin
      tick();
      n++;
      if (ack0 || ack1) begin
        if (nacks > 0) check("ack_spacing", 32'(cycle - last), 32'(3));
        last = cycle;
        nacks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_ack_count", 32'(nacks), 32'(4));
    if (nacks != 4) sb.delete();
    tick();

    // Reset in the middle of a read: no ack, read data returns to zero.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    tick();
    check("abort_busy_before", 32'(busy), 32'(1));
    reset = 1'b1;
    req0 = 1'b0;
    tick();
    check("abort_ack0", 32'(ack0), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rdata0", 32'(rdata0), 32'(0));
    check("abort_rdata1", 32'(rdata1), 32'(0));
    reset = 1'b0;
    mdl0 = 8'h00; mdl1 = 8'h00;
    for (int k = 0; k < 4; k++) tick();
    check("abort_idle_busy", 32'(busy), 32'(0));

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SRAM address width (16 locations).
REQ-002 Parameter DATA_W, default 8, SRAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req0 / req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read; valid while matching req high.
REQ-007 addr0 / addr1  input  ADDR_W each  target address.
REQ-008 wdata0 / wdata1  input  DATA_W each  write data.
REQ-009 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata0 / rdata1  output  DATA_W each  registered read data; valid when matching ack high.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 sram_address  output  ADDR_W  to SRAM address port.
REQ-013 sram_data_in  output  DATA_W  to SRAM write-data port.
REQ-014 sram_write_en  output  1  to SRAM write enable; SRAM writes on rising clk when high.
REQ-015 sram_data_out  input  DATA_W  asynchronous read data from SRAM.

Function
REQ-016 FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS (any req high at edge), ACCESS->DONE (always), DONE->IDLE (always).
REQ-017 In IDLE at edge with a request: latch winner id, we, addr, wdata into internal registers; enter ACCESS.
REQ-018 Single request: that requester wins.
REQ-019 Both req high: round-robin; winner is requester not served last; last_grant updates on every grant.
REQ-020 ACCESS: sram_address/sram_data_in driven from latched registers; sram_write_en = latched we; exactly one SRAM cycle per grant.
REQ-021 Edge leaving ACCESS: for reads, winner's rdata <= sram_data_out; for writes, winner's rdata unchanged; winner's ack <= 1.
REQ-022 DONE: ack of winner high for exactly this cycle; sram_write_en 0; other ack 0.
REQ-023 Latency: request sampled at edge E0 -> ack high during cycle after E1 -> next request sampled at E3 (one access per 3 cycles).
REQ-024 Requester holds req/we/addr/wdata stable until its ack; changes after the IDLE sample edge are ignored for the current access.
REQ-025 req still high during DONE is a new request, arbitrated normally in IDLE.
REQ-026 sram_write_en SHALL be 0 in IDLE and DONE; sram_address/sram_data_in hold latched values outside ACCESS.
REQ-027 Non-winner rdata and ack never change during another requester's access.

Reset
REQ-028 reset high at an edge: state IDLE, ack0/ack1 0, rdata0/rdata1 0, latched addr/wdata/we 0, last_grant = 1 (requester 0 wins first tie), busy 0.
REQ-029 Reset during ACCESS aborts access: no ack issued, rdata unchanged from reset value; SRAM write occurring at that same edge is permitted.
REQ-030 Requests are ignored on any edge where reset is high.

Configuration
REQ-031 Macro SRAM_ARB_FIXED_PRI_EN: defined -> requester 0 always wins simultaneous requests, last_grant unused; undefined -> round-robin per REQ-019.

Verification
REQ-032 reset, then req0 write addr 3 data 0xA5 alone -> sram_write_en high one cycle with sram_address 3; ack0 pulse 2 cycles after sample; ack1 never.
REQ-033 After REQ-032, req1 read addr 3 -> ack1 pulse with rdata1 = 0xA5; rdata0 unchanged.
REQ-034 req0 and req1 both held high, reads of addr 3 and 5 -> acks alternate 0,1,0,1 every 3 cycles (with SRAM_ARB_FIXED_PRI_EN: ack0 only).
REQ-035 Write all 16 addresses via req1 with data 8'h10+addr, read back via req0 -> 16/16 matches, addr 15 then 0 correct.
REQ-036 reset asserted during ACCESS of req0 read -> no ack0, state IDLE, busy 0, rdata0 = 0 next cycle.
REQ-037 Change addr0 from 2 to 9 one cycle after sample -> SRAM accessed at address 2 only.
